fetch_stage: RTL and testbench



---
 rtl/fetch_pkg.sv | 33 +++
 rtl/fetch_skid_buf.sv | 81 ++++++++
 rtl/fetch_stage.sv | 146 ++++++++++++++
 tb/tb_fetch_stage.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

  localparam int          XLEN      = 32;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    S_BOOT = 2'd0,
    S_RUN  = 2'd1,
    S_HALT = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [31:0]     instr;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_plus4;
    logic            fault;
  } fetch_bundle_t;

  // Value held by the output path while nothing valid has been delivered.
  localparam fetch_bundle_t IDLE_BUNDLE = '{
    instr:    NOP_INSTR,
    pc:       32'h0000_0000,
    pc_plus4: 32'h0000_0000,
    fault:    1'b0
  };

  // Sequential next address; wraps modulo 2^XLEN.
  function automatic logic [XLEN-1:0] pc_next(input logic [XLEN-1:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/fetch_skid_buf.sv
// Output register plus one skid entry for a fetch bundle, valid/ready on both
// sides. The input is ready whenever the skid entry is free; flush drops both
// entries.
module fetch_skid_buf
  import fetch_pkg::*;
(
  input  logic          clk_i,
  input  logic          reset_i,
  input  logic          flush_i,
  input  logic          in_valid_i,
  input  fetch_bundle_t in_data_i,
  output logic          in_ready_o,
  output logic          out_valid_o,
  input  logic          out_ready_i,
  output fetch_bundle_t out_data_o
);

  logic          out_valid_q, out_valid_d;
  fetch_bundle_t out_data_q,  out_data_d;
  logic          skid_valid_q, skid_valid_d;
  fetch_bundle_t skid_data_q,  skid_data_d;
  logic          consume_s;

  // Next-state for output register and skid entry
  always_comb begin
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    skid_valid_d = skid_valid_q;
    skid_data_d  = skid_data_q;
    consume_s    = out_valid_q && out_ready_i;
    if (flush_i) begin
      out_valid_d  = 1'b0;
      skid_valid_d = 1'b0;
    end else if (!out_valid_q || consume_s) begin
      if (skid_valid_q) begin
        // Oldest entry first: skid moves up, new data (if any) refills skid.
        out_valid_d  = 1'b1;
        out_data_d   = skid_data_q;
        skid_valid_d = in_valid_i;
        if (in_valid_i) begin
          skid_data_d = in_data_i;
        end else begin
          skid_data_d = skid_data_q;
        end
      end else if (in_valid_i) begin
        out_valid_d = 1'b1;
        out_data_d  = in_data_i;
      end else begin
        out_valid_d = 1'b0;
      end
    end else begin
      // Output stalled: park incoming data in the skid entry if free.
      if (in_valid_i && !skid_valid_q) begin
        skid_valid_d = 1'b1;
        skid_data_d  = in_data_i;
      end else begin
        skid_valid_d = skid_valid_q;
      end
    end
  end

  // Register update with synchronous reset
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      out_valid_q  <= 1'b0;
      out_data_q   <= IDLE_BUNDLE;
      skid_valid_q <= 1'b0;
      skid_data_q  <= IDLE_BUNDLE;
    end else begin
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      skid_valid_q <= skid_valid_d;
      skid_data_q  <= skid_data_d;
    end
  end

  assign in_ready_o  = !skid_valid_q;
  assign out_valid_o = out_valid_q;
  assign out_data_o  = out_data_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the PC, keeps at most one instruction-memory
// read in flight, and hands {instr, pc, pc+4, fault} to ID over valid/ready.
// EX redirects flush buffered output and squash the stale read in flight.
module fetch_stage
  import fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            reset,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [31:0]     imem_rdata,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            id_ready,
  output logic            if_valid,
  output logic [31:0]     if_instr,
  output logic [XLEN-1:0] if_pc,
  output logic [XLEN-1:0] if_pc_plus4,
  output logic            if_fault
);

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] req_pc_q, req_pc_d;
  logic            outstanding_q, outstanding_d;
  logic            drop_q, drop_d;
  logic            fault_pend_q, fault_pend_d;

  logic            skid_free_s;
  logic            out_valid_s;
  fetch_bundle_t   out_bundle_s;
  fetch_bundle_t   in_bundle_s;
  logic            in_valid_s;
  logic            misaligned_s;
  logic            wr_s;
  logic            fault_inject_s;
  logic            space_s;
  logic            can_issue_s;
  logic            fire_s;

  // Request issue, response acceptance and bundle selection
  always_comb begin
    misaligned_s   = (redirect_pc[1:0] != 2'b00);
    // Only a live, non-squashed response for our own request is written.
    wr_s           = imem_rvalid && outstanding_q && !drop_q && !redirect_valid;
    // Space must also hold once this cycle's response lands in the skid.
    space_s        = skid_free_s && !(wr_s && out_valid_s && !id_ready);
    can_issue_s    = (state_q == S_RUN) && space_s && (!outstanding_q || imem_rvalid);
    imem_req       = can_issue_s && !redirect_valid;
    fire_s         = imem_req && imem_gnt;
    fault_inject_s = (state_q == S_HALT) && fault_pend_q && !redirect_valid;
    in_valid_s     = wr_s || fault_inject_s;
    if (fault_inject_s) begin
      in_bundle_s = '{instr: NOP_INSTR, pc: pc_q, pc_plus4: pc_next(pc_q), fault: 1'b1};
    end else begin
      in_bundle_s = '{instr: imem_rdata, pc: req_pc_q, pc_plus4: pc_next(req_pc_q), fault: 1'b0};
    end
  end

  // Next-state for FSM, PC and read-tracking flags
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    req_pc_d      = req_pc_q;
    outstanding_d = outstanding_q;
    drop_d        = drop_q;
    fault_pend_d  = fault_pend_q;
    if (redirect_valid) begin
      pc_d          = redirect_pc;
      drop_d        = (outstanding_q && !imem_rvalid) || (imem_req && imem_gnt);
      // A squashed read is still in flight and blocks new issue until it returns.
      outstanding_d = (outstanding_q && !imem_rvalid) || (imem_req && imem_gnt);
      fault_pend_d  = misaligned_s;
      state_d       = misaligned_s ? S_HALT : S_RUN;
    end else begin
      case (state_q)
        S_BOOT:  state_d = S_RUN;
        S_RUN:   state_d = S_RUN;
        S_HALT:  state_d = S_HALT;
        default: state_d = S_BOOT;
      endcase
      if (fire_s) begin
        pc_d          = pc_next(pc_q);
        req_pc_d      = pc_q;
        outstanding_d = 1'b1;
      end else if (imem_rvalid) begin
        outstanding_d = 1'b0;
      end else begin
        outstanding_d = outstanding_q;
      end
      if (drop_q && imem_rvalid) begin
        drop_d = 1'b0;
      end else begin
        drop_d = drop_q;
      end
      if (fault_inject_s) begin
        fault_pend_d = 1'b0;
      end else begin
        fault_pend_d = fault_pend_q;
      end
    end
  end

  // Control registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_BOOT;
      pc_q          <= RESET_PC;
      req_pc_q      <= 32'h0000_0000;
      outstanding_q <= 1'b0;
      drop_q        <= 1'b0;
      fault_pend_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      req_pc_q      <= req_pc_d;
      outstanding_q <= outstanding_d;
      drop_q        <= drop_d;
      fault_pend_q  <= fault_pend_d;
    end
  end

  fetch_skid_buf u_skid (
    .clk_i       (clk),
    .reset_i     (reset),
    .flush_i     (redirect_valid),
    .in_valid_i  (in_valid_s),
    .in_data_i   (in_bundle_s),
    .in_ready_o  (skid_free_s),
    .out_valid_o (out_valid_s),
    .out_ready_i (id_ready),
    .out_data_o  (out_bundle_s)
  );

  assign imem_addr   = pc_q;
  assign if_valid    = out_valid_s;
  assign if_instr    = out_bundle_s.instr;
  assign if_pc       = out_bundle_s.pc;
  assign if_pc_plus4 = out_bundle_s.pc_plus4;
  assign if_fault    = out_bundle_s.fault;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: streaming, stall/skid, redirects (with and
// without a squashed read in flight), misaligned halt, PC wrap, mid-fetch reset.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_gnt;
  logic        rv_en;
  logic        id_ready;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        redir2_valid;
  logic [31:0] redir2_pc;

  logic        imem_req,  imem_rvalid,  if_valid,  if_fault;
  logic [31:0] imem_addr, imem_rdata,   if_instr,  if_pc,  if_pc_plus4;
  logic        imem_req2, imem_rvalid2, if_valid2, if_fault2;
  logic [31:0] imem_addr2, imem_rdata2, if_instr2, if_pc2, if_pc_plus42;

  logic        pend  = 1'b0;
  logic [31:0] paddr = 32'h0;
  logic        pend2  = 1'b0;
  logic [31:0] paddr2 = 32'h0;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return a ^ 32'h5A00_0033;
  endfunction

  // Memory models: grant as driven, response once rv_en allows it
  always @(posedge clk) begin
    if (imem_req && mem_gnt) begin
      pend  <= 1'b1;
      paddr <= imem_addr;
    end else if (imem_rvalid) begin
      pend <= 1'b0;
    end
    if (imem_req2 && mem_gnt) begin
      pend2  <= 1'b1;
      paddr2 <= imem_addr2;
    end else if (imem_rvalid2) begin
      pend2 <= 1'b0;
    end
  end

  assign imem_rvalid  = pend && rv_en;
  assign imem_rdata   = instr_of(paddr);
  assign imem_rvalid2 = pend2 && rv_en;
  assign imem_rdata2  = instr_of(paddr2);

  fetch_stage #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .reset(reset),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(mem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .id_ready(id_ready),
    .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc),
    .if_pc_plus4(if_pc_plus4), .if_fault(if_fault)
  );

  fetch_stage #(.RESET_PC(32'hFFFF_FFFC)) dut2 (
    .clk(clk), .reset(reset),
    .imem_req(imem_req2), .imem_addr(imem_addr2), .imem_gnt(mem_gnt),
    .imem_rvalid(imem_rvalid2), .imem_rdata(imem_rdata2),
    .redirect_valid(redir2_valid), .redirect_pc(redir2_pc),
    .id_ready(id_ready),
    .if_valid(if_valid2), .if_instr(if_instr2), .if_pc(if_pc2),
    .if_pc_plus4(if_pc_plus42), .if_fault(if_fault2)
  );

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; mem_gnt = 1'b0; rv_en = 1'b1; id_ready = 1'b1;
    redirect_valid = 1'b0; redirect_pc = 32'h0;
    redir2_valid = 1'b0; redir2_pc = 32'h0;
    step; step;
    // Reset state
    chk1 ("rst_valid", if_valid, 1'b0);
    chk32("rst_instr", if_instr, 32'h0000_0013);
    chk32("rst_pc",    if_pc,    32'h0);
    chk32("rst_pc4",   if_pc_plus4, 32'h0);
    chk1 ("rst_fault", if_fault, 1'b0);
    chk1 ("rst_req",   imem_req, 1'b0);
    reset = 1'b0; mem_gnt = 1'b1;

    // Streaming: addresses 0,4,8,...; outputs follow two cycles behind
    step;
    chk1 ("s_req0", imem_req, 1'b1);  chk32("s_addr0", imem_addr, 32'h0);
    chk1 ("s_val0", if_valid, 1'b0);
    chk32("w_addr0", imem_addr2, 32'hFFFF_FFFC); chk1("w_req0", imem_req2, 1'b1);
    step;
    chk32("s_addr1", imem_addr, 32'h4); chk1("s_val1", if_valid, 1'b0);
    chk32("w_addr1", imem_addr2, 32'h0);
    step;
    chk1 ("s_val2", if_valid, 1'b1);  chk32("s_pc2", if_pc, 32'h0);
    chk32("s_pc4_2", if_pc_plus4, 32'h4); chk32("s_ins2", if_instr, instr_of(32'h0));
    chk32("s_addr2", imem_addr, 32'h8);
    chk32("w_pc2", if_pc2, 32'hFFFF_FFFC); chk32("w_pc4_2", if_pc_plus42, 32'h0);
    step;
    chk1 ("s_val3", if_valid, 1'b1);  chk32("s_pc3", if_pc, 32'h4);
    chk32("s_ins3", if_instr, instr_of(32'h4)); chk32("s_addr3", imem_addr, 32'hC);
    chk32("w_pc3", if_pc2, 32'h0);  chk32("w_ins3", if_instr2, instr_of(32'h0));
    step;
    chk1 ("s_val4", if_valid, 1'b1);  chk32("s_pc4", if_pc, 32'h8);
    chk32("s_pc4_4", if_pc_plus4, 32'hC);

    // Stall three cycles: output held, skid takes word 0xC, no new request
    id_ready = 1'b0; #1;
    chk1("st_req0", imem_req, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step;
      chk1 ("st_val", if_valid, 1'b1);
      chk32("st_pc",  if_pc, 32'h8);
      chk32("st_ins", if_instr, instr_of(32'h8));
      chk1 ("st_req", imem_req, 1'b0);
    end
    id_ready = 1'b1; #1;
    chk1("st_req_rel", imem_req, 1'b0);
    step;
    chk32("st_pcC", if_pc, 32'hC); chk1("st_valC", if_valid, 1'b1);
    chk1 ("st_reqC", imem_req, 1'b1); chk32("st_addrC", imem_addr, 32'h10);
    step;
    chk1 ("st_bubble", if_valid, 1'b0); chk32("st_addr14", imem_addr, 32'h14);
    step;
    chk1 ("st_val10", if_valid, 1'b1); chk32("st_pc10", if_pc, 32'h10);

    // Redirect to 0x100 while the read of 0x14 returns in the same cycle
    redirect_valid = 1'b1; redirect_pc = 32'h100; #1;
    chk1("rd_req_blk", imem_req, 1'b0);
    step;
    redirect_valid = 1'b0; #1;
    chk1 ("rd_val", if_valid, 1'b0);
    chk1 ("rd_req", imem_req, 1'b1); chk32("rd_addr", imem_addr, 32'h100);
    step;
    chk32("rd_addr1", imem_addr, 32'h104); chk1("rd_val1", if_valid, 1'b0);
    step;
    chk1 ("rd_val2", if_valid, 1'b1); chk32("rd_pc", if_pc, 32'h100);
    chk32("rd_ins", if_instr, instr_of(32'h100));

    // Redirect to 0x200 with the read of 0x104 still in flight: it is squashed
    rv_en = 1'b0; #1;
    chk1("dr_req_wait", imem_req, 1'b0);
    step;
    chk1("dr_val", if_valid, 1'b0);
    redirect_valid = 1'b1; redirect_pc = 32'h200;
    step;
    redirect_valid = 1'b0; #1;
    chk1("dr_req_out", imem_req, 1'b0);
    rv_en = 1'b1; #1;
    chk1 ("dr_req", imem_req, 1'b1); chk32("dr_addr", imem_addr, 32'h200);
    step;
    chk1 ("dr_stale", if_valid, 1'b0);
    step;
    chk1 ("dr_val2", if_valid, 1'b1); chk32("dr_pc", if_pc, 32'h200);
    chk32("dr_ins", if_instr, instr_of(32'h200));

    // Misaligned redirect: one fault bundle, no requests, held under stall
    redirect_valid = 1'b1; redirect_pc = 32'h102; #1;
    chk1("ma_req0", imem_req, 1'b0);
    step;
    redirect_valid = 1'b0; #1;
    chk1("ma_val0", if_valid, 1'b0); chk1("ma_req1", imem_req, 1'b0);
    step;
    chk1 ("ma_val", if_valid, 1'b1);  chk1("ma_fault", if_fault, 1'b1);
    chk32("ma_ins", if_instr, 32'h0000_0013); chk32("ma_pc", if_pc, 32'h102);
    chk32("ma_pc4", if_pc_plus4, 32'h106); chk1("ma_req2", imem_req, 1'b0);
    id_ready = 1'b0;
    step;
    chk1 ("ma_hold_v", if_valid, 1'b1); chk32("ma_hold_pc", if_pc, 32'h102);
    id_ready = 1'b1;
    step;
    chk1("ma_gone", if_valid, 1'b0); chk1("ma_req3", imem_req, 1'b0);
    step;
    chk1("ma_once", if_valid, 1'b0); chk1("ma_req4", imem_req, 1'b0);
    redirect_valid = 1'b1; redirect_pc = 32'h200; #1;
    chk1("ma_rd_req", imem_req, 1'b0);
    step;
    redirect_valid = 1'b0; #1;
    chk1 ("ma_resume", imem_req, 1'b1); chk32("ma_raddr", imem_addr, 32'h200);
    step;
    chk32("ma_raddr1", imem_addr, 32'h204);
    step;
    chk1 ("ma_rval", if_valid, 1'b1); chk32("ma_rpc", if_pc, 32'h200);
    chk1 ("ma_rfault", if_fault, 1'b0);

    // Reset with a read in flight and valid output; stale response ignored
    reset = 1'b1; rv_en = 1'b0;
    step;
    chk1("mr_val", if_valid, 1'b0); chk1("mr_req", imem_req, 1'b0);
    reset = 1'b0; rv_en = 1'b1; #1;
    chk1("mr_boot_req", imem_req, 1'b0);
    step;
    chk1 ("mr_req1", imem_req, 1'b1); chk32("mr_addr", imem_addr, 32'h0);
    chk1 ("mr_stale", if_valid, 1'b0);
    step;
    chk1 ("mr_val1", if_valid, 1'b0);
    step;
    chk1 ("mr_val2", if_valid, 1'b1); chk32("mr_pc", if_pc, 32'h0);
    chk32("mr_ins", if_instr, instr_of(32'h0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
